// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu: memory-stage load/store unit.
//
// Takes the ALU result as the effective address, plus the rs2 store data and
// the RV32I funct3. It issues one transaction at a time on a valid/ready data
// memory port and returns formatted load data or a store acknowledge to
// writeback.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake from EX (ready only while idle)
//   is_load, is_store   request kind (exactly one must be set)
//   funct3              RV32I load/store width/sign encoding
//   addr                effective address
//   store_data          rs2 value
//   mem_req/mem_ready   memory request handshake
//   mem_we, mem_addr    write enable, word-aligned address
//   mem_wdata/mem_wstrb lane-positioned store data and byte enables
//   mem_rvalid/rdata    load return data (earliest the cycle after handshake)
//   rsp_valid           one-cycle completion pulse
//   rsp_data            formatted load data (0 for stores and errors)
//   rsp_err             00 ok, 01 misaligned, 10 illegal, 11 timeout
// -----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err
);

    // The counter only has to represent 0 .. TIMEOUT_CYCLES-1: the cycle in
    // which it holds the last value is the final cycle allowed.
    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic f3_legal(input logic load, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = load;
            default:                f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: f3_aligned = 1'b1;
            3'b001, 3'b101: f3_aligned = (off[0] == 1'b0);
            3'b010:         f3_aligned = (off == 2'b00);
            default:        f3_aligned = 1'b0;
        endcase
    endfunction

    // Replicating the low byte/half across the word puts it in every lane;
    // the strobes then pick the lane that is actually written.
    function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  st_wdata = {4{sd[7:0]}};
            3'b001:  st_wdata = {2{sd[15:0]}};
            3'b010:  st_wdata = sd;
            default: st_wdata = 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] st_wstrb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  st_wstrb = 4'b0001 << off;
            3'b001:  st_wstrb = 4'b0011 << {off[1], 1'b0};
            3'b010:  st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ld_format(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rd >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  ld_format = {{24{b[7]}}, b};
            3'b100:  ld_format = {24'd0, b};
            3'b001:  ld_format = {{16{h[15]}}, h};
            3'b101:  ld_format = {16'd0, h};
            3'b010:  ld_format = rd;
            default: ld_format = 32'd0;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       lat_f3_r, lat_f3_s;
    logic [1:0]       lat_off_r, lat_off_s;
    logic             lat_load_r, lat_load_s;
    logic             mem_req_r, mem_req_s;
    logic             mem_we_r, mem_we_s;
    logic [31:0]      mem_addr_r, mem_addr_s;
    logic [31:0]      mem_wdata_r, mem_wdata_s;
    logic [3:0]       mem_wstrb_r, mem_wstrb_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [31:0]      rsp_data_r, rsp_data_s;
    logic [1:0]       rsp_err_r, rsp_err_s;

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        lat_f3_s    = lat_f3_r;
        lat_off_s   = lat_off_r;
        lat_load_s  = lat_load_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wstrb_s = mem_wstrb_r;
        rsp_valid_s = 1'b0;
        rsp_data_s  = rsp_data_r;
        rsp_err_s   = rsp_err_r;

        case (state_r)
            ST_IDLE: begin
                if (req_valid && (is_load || is_store)) begin
                    lat_f3_s   = funct3;
                    lat_off_s  = addr[1:0];
                    lat_load_s = is_load;
                    // Illegal encodings win over misalignment.
                    if ((is_load && is_store) || !f3_legal(is_load, funct3)) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = 32'd0;
                        rsp_err_s   = ERR_ILLEGAL;
                    end else if (!f3_aligned(funct3, addr[1:0])) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = 32'd0;
                        rsp_err_s   = ERR_MISALGN;
                    end else begin
                        state_s    = ST_REQ;
                        cnt_s      = {CNT_W{1'b0}};
                        mem_req_s  = 1'b1;
                        mem_we_s   = is_store;
                        mem_addr_s = {addr[31:2], 2'b00};
                        if (is_store) begin
                            mem_wdata_s = st_wdata(funct3, store_data);
                            mem_wstrb_s = st_wstrb(funct3, addr[1:0]);
                        end else begin
                            mem_wdata_s = 32'd0;
                            mem_wstrb_s = 4'b0000;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (mem_ready) begin
                    mem_req_s = 1'b0;
                    if (lat_load_r) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = 32'd0;
                        rsp_err_s   = ERR_OK;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    mem_req_s   = 1'b0;
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = 32'd0;
                    rsp_err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = ST_REQ;
                end
            end

            ST_WAIT: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (mem_rvalid) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = ld_format(lat_f3_r, lat_off_r, mem_rdata);
                    rsp_err_s   = ERR_OK;
                end else if (cnt_r == CNT_LAST) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = 32'd0;
                    rsp_err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_RESP: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            lat_f3_r    <= 3'b000;
            lat_off_r   <= 2'b00;
            lat_load_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_wstrb_r <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_err_r   <= 2'b00;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            lat_f3_r    <= lat_f3_s;
            lat_off_r   <= lat_off_s;
            lat_load_r  <= lat_load_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu: directed self-checking bench for lsu. dut drives the default
// timeout; dut_t uses TIMEOUT_CYCLES = 4 with its own handshake inputs.
// -----------------------------------------------------------------------------
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid2 = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        mem_ready = 1'b1, mem_ready2 = 1'b1;
    logic        mem_rvalid = 1'b0, mem_rvalid2 = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_ready, mem_req, mem_we, rsp_valid;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [3:0]  mem_wstrb;
    logic [1:0]  rsp_err;

    logic        req_ready2, mem_req2, mem_we2, rsp_valid2;
    logic [31:0] mem_addr2, mem_wdata2, rsp_data2;
    logic [3:0]  mem_wstrb2;
    logic [1:0]  rsp_err2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [127:0] got, exp;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    lsu #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .mem_req(mem_req2), .mem_ready(mem_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_wstrb(mem_wstrb2), .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_err(rsp_err2)
    );

    // Present one request for one cycle; returns at the negedge after accept.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; store_data = sd;
        @(negedge clk);
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        got = {req_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err};
        exp = {1'b1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL reset_state: got %h want %h", got, exp); end
        got = {req_ready2, mem_req2, rsp_valid2};
        exp = {1'b1, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL reset_state_t: got %h want %h", got, exp); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_lanes();
        mem_ready = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        got = {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, req_ready, rsp_valid};
        exp = {1'b1, 1'b1, 4'b1000, 32'h0000_1000, 32'hDDDD_DDDD, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sb_request: got %h want %h", got, exp); end
        @(negedge clk);
        got = {rsp_valid, rsp_err, rsp_data, mem_req};
        exp = {1'b1, 2'b00, 32'd0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sb_response: got %h want %h", got, exp); end
        @(negedge clk);
        got = {rsp_valid, req_ready};
        exp = {1'b0, 1'b1};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sb_pulse_end: got %h want %h", got, exp); end
        issue(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1122_3344);
        got = {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata};
        exp = {1'b1, 1'b1, 4'b1100, 32'h0000_1000, 32'h3344_3344};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sh_request: got %h want %h", got, exp); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
        logic [31:0] as  [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2001};
        logic [31:0] rds [6] = '{32'h0080_FF00, 32'h0080_FF00, 32'h8001_1234, 32'h8001_1234,
                                 32'h8001_1234, 32'h0080_FF00};
        logic [31:0] exs [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h8001_1234,
                                 32'h0000_1234, 32'hFFFF_FFFF};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b0, f3s[i], as[i], 32'hFFFF_FFFF);
            got = {mem_req, mem_we, mem_wstrb, mem_addr};
            exp = {1'b1, 1'b0, 4'b0000, 32'h0000_2000};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL load%0d_request: got %h want %h", i, got, exp); end
            @(negedge clk);
            got = {mem_req, rsp_valid};
            exp = {1'b0, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL load%0d_wait: got %h want %h", i, got, exp); end
            mem_rvalid = 1'b1; mem_rdata = rds[i];
            @(negedge clk);
            mem_rvalid = 1'b0;
            got = {rsp_valid, rsp_err, rsp_data};
            exp = {1'b1, 2'b00, exs[i]};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL load%0d_data: got %h want %h", i, got, exp); end
            @(negedge clk);
            got = {rsp_valid, req_ready, rsp_data};
            exp = {1'b0, 1'b1, exs[i]};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL load%0d_hold: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_errors();
        logic        lds [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        sts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b011};
        logic [31:0] as  [6] = '{32'h2001, 32'h2003, 32'h2000, 32'h2000, 32'h2000, 32'h2001};
        logic [1:0]  ers [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 6; i++) begin
            issue(lds[i], sts[i], f3s[i], as[i], 32'h5555_AAAA);
            got = {rsp_valid, rsp_err, rsp_data, mem_req};
            exp = {1'b1, ers[i], 32'd0, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL err%0d_response: got %h want %h", i, got, exp); end
            @(negedge clk);
            got = {rsp_valid, req_ready, mem_req, rsp_err};
            exp = {1'b0, 1'b1, 1'b0, ers[i]};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL err%0d_after: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_ignore();
        issue(1'b0, 1'b0, 3'b010, 32'h0000_3000, 32'd0);
        got = {req_ready, mem_req, rsp_valid};
        exp = {1'b1, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ignore_no_kind: got %h want %h", got, exp); end
    endtask

    task automatic test_backpressure();
        mem_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            got = {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, req_ready, rsp_valid};
            exp = {1'b1, 1'b1, 4'b1111, 32'h0000_3000, 32'h1234_5678, 1'b0, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL bp_stall%0d: got %h want %h", i, got, exp); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        got = {rsp_valid, rsp_err, mem_req};
        exp = {1'b1, 2'b00, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL bp_release: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_00AB);
        got = {mem_wstrb, mem_wdata};
        exp = {4'b0001, 32'hABAB_ABAB};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_first: got %h want %h", got, exp); end
        // Second request is held from the RESP cycle onward.
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b001;
        addr = 32'h0000_0022; store_data = 32'h0000_BEEF;
        @(negedge clk);
        got = {rsp_valid, req_ready};
        exp = {1'b1, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_resp: got %h want %h", got, exp); end
        @(negedge clk);
        got = {req_ready, mem_req, rsp_valid};
        exp = {1'b1, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_idle: got %h want %h", got, exp); end
        @(negedge clk);
        req_valid = 1'b0; is_store = 1'b0;
        got = {mem_req, mem_wstrb, mem_addr, mem_wdata};
        exp = {1'b1, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_second: got %h want %h", got, exp); end
        @(negedge clk);
        got = {rsp_valid, rsp_err};
        exp = {1'b1, 2'b00};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_second_resp: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            // k = 0: load accepted but never returns data; k = 1: store never accepted.
            mem_ready2 = (k == 0);
            req_valid2 = 1'b1; is_load = (k == 0); is_store = (k != 0);
            funct3 = 3'b010; addr = 32'h0000_4000; store_data = 32'h0BAD_F00D;
            @(negedge clk);
            req_valid2 = 1'b0; is_load = 1'b0; is_store = 1'b0;
            got = {mem_req2, rsp_valid2};
            exp = {1'b1, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL to%0d_request: got %h want %h", k, got, exp); end
            cyc = 1;
            while (rsp_valid2 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            got = {cyc[7:0], rsp_valid2, rsp_err2, rsp_data2, mem_req2};
            exp = {8'd5, 1'b1, 2'b11, 32'd0, 1'b0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL to%0d_response: got %h want %h", k, got, exp); end
            @(negedge clk);
            got = {rsp_valid2, req_ready2};
            exp = {1'b0, 1'b1};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL to%0d_idle: got %h want %h", k, got, exp); end
        end
        mem_ready2 = 1'b1;
    endtask

    task automatic test_reset_inflight();
        mem_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h0000_0001);
        #1 rst = 1'b1;
        #1;
        got = {mem_req, req_ready, mem_wstrb, mem_addr};
        exp = {1'b0, 1'b1, 4'b0000, 32'd0};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_in_req: got %h want %h", got, exp); end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        got = {mem_req, req_ready, rsp_valid, rsp_data, rsp_err};
        exp = {1'b0, 1'b1, 1'b0, 32'd0, 2'b00};
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_in_wait: got %h want %h", got, exp); end
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {rsp_valid, req_ready, rsp_data};
            exp = {1'b0, 1'b1, 32'd0};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL stale_rvalid%0d: got %h want %h", i, got, exp); end
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_loads();
        test_errors();
        test_ignore();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the memory stage, directly downstream of the integer ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3.
- Drives a single-outstanding valid/ready data-memory port, and returns sign/zero-extended load data or a store acknowledge to writeback.
- Flags misaligned, illegal-funct3 and memory-timeout errors. Holds off the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed from REQ entry to mem_ready (store) or mem_rvalid (load) before a timeout error is raised; min 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request from EX stage
- req_ready  out  1  LSU idle and can accept a request
- is_load  in  1  request is a load
- is_store  in  1  request is a store
- funct3  in  3  RV32I load/store funct3
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- mem_req  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-positioned store data
- mem_wstrb  out  4  byte enables (0000 on loads)
- mem_rvalid  in  1  read data valid; earliest the cycle after the load handshake
- mem_rdata  in  32  read word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  formatted load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal, 11 timeout

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0 except req_ready = 1. Timeout counter 0. An in-flight memory transaction is abandoned; mem_req drops without waiting for the clock.
- req_ready = (state == IDLE). All mem_* and rsp_* outputs are registered.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accept on req_valid with is_load ^ is_store. Latch funct3, addr[1:0] and is_load.
  - Legal and aligned -> REQ; load mem_addr, mem_we, mem_wdata, mem_wstrb; set mem_req = 1.
  - Misaligned -> RESP with err 01. No memory access.
  - Illegal funct3, or is_load & is_store both set -> RESP with err 10. No memory access.
  - req_valid with neither is_load nor is_store: ignored, stay IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other encodings are illegal.
- Alignment:
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 00.
  - Alignment is checked only for legal funct3; illegal takes priority.
- Store lanes:
  - SB: wdata = {4{sd[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{sd[15:0]}}, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wdata = sd, wstrb = 1111.
- REQ:
  - Hold mem_req and all mem_* stable until mem_ready.
  - On handshake: mem_req -> 0. Store -> RESP, err 00. Load -> WAIT.
- WAIT:
  - On mem_rvalid: select byte/half by latched addr[1:0], sign- or zero-extend per funct3, register into rsp_data -> RESP.
  - mem_rvalid outside WAIT is ignored.
- Timeout:
  - Counter clears on REQ entry and increments each cycle in REQ or WAIT.
  - If it reaches TIMEOUT_CYCLES with no completing event: mem_req -> 0, -> RESP with err 11, rsp_data 0.
  - A completing event in the same cycle as the limit wins over timeout.
- RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE. rsp_data and rsp_err hold until the next RESP.
- Latency:
  - Store with mem_ready already high: accept at cycle N, mem_req at N+1, rsp_valid at N+2.
  - Load with rvalid one cycle after the handshake: rsp_valid at N+3.
  - Error detected at accept: rsp_valid at N+1.
- Throughput: one transaction at a time; the next request is accepted the cycle after RESP.

Test Plan:
- SB: addr 0x1003, sd 0xAABBCCDD, mem_ready high -> mem_addr 0x1000, wstrb 1000, wdata 0xDDDDDDDD, we 1; rsp_valid at cycle 2, err 00.
- LB then LBU: addr 0x2002, rdata 0x0080FF00 -> LB rsp_data 0xFFFFFF80; LBU rsp_data 0x00000080; wstrb 0000.
- LH: addr 0x2002, rdata 0x8001_1234 -> 0xFFFF8001. LW: addr 0x2000 -> 0x80011234, rsp_valid at cycle 3.
- LW at addr 0x2001 -> no mem_req, rsp_err 01 at cycle 1. Load funct3 011 -> err 10. Store funct3 100 -> err 10.
- Backpressure: SW with mem_ready low for 5 cycles -> mem_req and mem_* stable, req_ready 0. With TIMEOUT_CYCLES 4 and rvalid never asserted -> rsp_err 11, mem_req dropped.
- rst asserted in WAIT -> mem_req 0 and req_ready 1 immediately. Stale mem_rvalid after reset -> no rsp_valid.
